text_mem_writer: RTL
====================

# text_mem_writer

Write-side companion of the text scroll streamer. Accepts an ASCII character stream with a valid/ready handshake and writes it sequentially into the shared 2^ADDR_W x 8 text RAM, using a wrapping write pointer. When a string completes, it publishes a descriptor (start address, length) that the scroll streamer uses directly as its `mem_addr`/`length`/`start` inputs. Sits between the UI text sources (keypad/menu/caller-ID formatters) and the text RAM.

## Interface
- ADDR_W, 11, text RAM address width; also the width of the descriptor address and length.
- MAX_LEN, 2047, maximum stored string length; legal range 1..2^ADDR_W-1.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- char_in  in  8  ASCII character
- char_valid  in  1  char_in valid
- char_last  in  1  char_in is final character of string; qualified by char_valid
- char_ready  out  1  block accepts char_in this cycle
- mem_we  out  1  text RAM write strobe
- mem_waddr  out  ADDR_W  text RAM write address
- mem_wdata  out  8  text RAM write data
- desc_valid  out  1  descriptor available; held until desc_ack
- desc_addr  out  ADDR_W  first address of string
- desc_length  out  ADDR_W  number of stored characters (≥1)
- desc_trunc  out  1  string exceeded MAX_LEN and was cut
- desc_ack  in  1  consumer took descriptor

## Operation
- Accept = char_valid & char_ready, sampled at rising edge. Every accepted character is data (no empty strings).
- States: IDLE, FILL, TERM (macro only), DESC, DRAIN.
- char_ready = 1 in IDLE, FILL, DRAIN; 0 in TERM, DESC (combinational from state).
- IDLE: on accept, latch start = wr_ptr, count = 1, write char; -> FILL, or -> DESC/TERM if char_last or MAX_LEN = 1.
- FILL: on accept, write char, count += 1. If char_last -> DESC (TERM if macro). Else if count reaches MAX_LEN -> DESC (TERM if macro) with trunc set.
- Write: mem_we = 1, mem_waddr = wr_ptr, mem_wdata = char; wr_ptr = wr_ptr + 1 mod 2^ADDR_W. Wrap is silent. Old text is overwritten without protection.
- DESC: desc_valid = 1, with desc_addr = start, desc_length = count, desc_trunc = trunc, all stable. On desc_ack -> DRAIN if trunc, else IDLE. desc_ack is ignored outside DESC.
- DRAIN: accepted characters are discarded (mem_we = 0, wr_ptr unchanged) until a char_last is accepted -> IDLE. trunc clears on leaving DRAIN.
- One descriptor is outstanding at a time. The source is backpressured until ack.

## Timing
- Reset: state IDLE, wr_ptr = 0, mem_we = 0, mem_waddr = 0, mem_wdata = 0, desc_valid = 0, desc_addr = 0, desc_length = 0, desc_trunc = 0; char_ready = 1 the first cycle after reset. Reset mid-string drops the partial string; no descriptor is issued.
- mem_we/mem_waddr/mem_wdata are registered and appear the cycle after acceptance, for exactly one cycle per character.
- desc_valid rises the cycle after the final write strobe edge. It coincides with that last mem_we cycle when the macro is off, and follows the terminator write when the macro is on.
- Ack sampled with desc_valid high: desc_valid = 0 and char_ready = 1 next cycle. This holds even if ack arrives in the first desc_valid cycle.
- Throughput: one character per clock while in FILL.

## Configuration
- TEXT_WR_NULL_TERM_EN defined: after the last stored character (including the truncation point), TERM writes 0x00 at wr_ptr for one cycle. wr_ptr advances past the terminator. desc_length excludes the terminator. DESC is entered the next cycle.
- Not defined: TERM does not exist, no terminator is written, and the FSM goes straight to DESC.

## Test plan
- Reset: all outputs 0, char_ready = 1; char_valid held low for 10 cycles -> no mem_we.
- "HI" (0x48, 0x49 with last) from reset -> writes 0x48@0, 0x49@1; desc_addr = 0, desc_length = 2, desc_trunc = 0. Ack -> next string starts at 2.
- Wrap: 2046 chars in one string, then "ABCD" -> writes at 2046, 2047, 0, 1; desc_addr = 2046, desc_length = 4.
- Truncation, MAX_LEN = 4: 6-char string -> 4 writes @0..3, desc_length = 4, desc_trunc = 1. After ack, chars 5-6 accepted with no mem_we. Next "Z" is written @4.
- Backpressure: char_valid held while desc_valid, ack delayed 5 cycles -> char_ready = 0 and no mem_we for those cycles. Ack and desc_valid in the same cycle -> char_ready = 1 next cycle.
- TEXT_WR_NULL_TERM_EN: "A" (last) -> 0x41@0, 0x00@1, desc_length = 1; next string starts @2.

Source files
------------

// File: rtl/text_mem_writer.sv
// text_mem_writer
//   Write side of the text scroll path. Takes an ASCII character stream
//   (valid/ready) and writes it sequentially into the shared text RAM through
//   a wrapping write pointer. When a string completes it publishes a
//   descriptor (start address, length, truncated flag) and holds it until the
//   consumer acknowledges it.
//
//   Optional build macro: TEXT_WR_NULL_TERM_EN. When it is defined, a 0x00
//   terminator is written after every stored string. The terminator is not
//   counted in desc_length.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   char_in/valid/last  input character stream; char_last marks the final char
//   char_ready          block accepts char_in this cycle
//   mem_we/waddr/wdata  registered text RAM write port
//   desc_valid/addr/length/trunc  string descriptor, held until desc_ack
//   desc_ack            consumer took the descriptor
module text_mem_writer #(
    parameter int ADDR_W  = 11,
    parameter int MAX_LEN = 2047
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        char_in,
    input  logic              char_valid,
    input  logic              char_last,
    output logic              char_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [7:0]        mem_wdata,
    output logic              desc_valid,
    output logic [ADDR_W-1:0] desc_addr,
    output logic [ADDR_W-1:0] desc_length,
    output logic              desc_trunc,
    input  logic              desc_ack
);

`ifdef TEXT_WR_NULL_TERM_EN
    typedef enum logic [2:0] {S_IDLE, S_FILL, S_TERM, S_DESC, S_DRAIN} state_t;
    // A completed string first passes through the terminator write.
    localparam state_t S_DONE = S_TERM;
`else
    typedef enum logic [2:0] {S_IDLE, S_FILL, S_DESC, S_DRAIN} state_t;
    localparam state_t S_DONE = S_DESC;
`endif

    localparam logic [ADDR_W-1:0] MAX_LEN_W = ADDR_W'(MAX_LEN);
    localparam bit                MAX_ONE   = (MAX_LEN == 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] wr_ptr, ptr_nxt;
    logic [ADDR_W-1:0] start, start_nxt;
    logic [ADDR_W-1:0] count, count_nxt;
    logic              trunc, trunc_nxt;
    logic              we_nxt;
    logic [ADDR_W-1:0] waddr_nxt;
    logic [7:0]        wdata_nxt;
    logic              accept;
    logic [ADDR_W-1:0] count_inc;

    assign char_ready  = (state == S_IDLE) || (state == S_FILL) || (state == S_DRAIN);
    assign accept      = char_valid && char_ready;
    assign count_inc   = count + 1'b1;

    assign desc_valid  = (state == S_DESC);
    assign desc_addr   = start;
    assign desc_length = count;
    assign desc_trunc  = trunc;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = wr_ptr;
        start_nxt = start;
        count_nxt = count;
        trunc_nxt = trunc;
        we_nxt    = 1'b0;
        waddr_nxt = mem_waddr;
        wdata_nxt = mem_wdata;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    start_nxt = wr_ptr;
                    count_nxt = ADDR_W'(1);
                    we_nxt    = 1'b1;
                    waddr_nxt = wr_ptr;
                    wdata_nxt = char_in;
                    ptr_nxt   = wr_ptr + 1'b1;
                    // With a one-character limit, anything but a final char is a cut.
                    trunc_nxt = !char_last && MAX_ONE;
                    state_nxt = (char_last || MAX_ONE) ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                if (accept) begin
                    count_nxt = count_inc;
                    we_nxt    = 1'b1;
                    waddr_nxt = wr_ptr;
                    wdata_nxt = char_in;
                    ptr_nxt   = wr_ptr + 1'b1;
                    if (char_last) begin
                        state_nxt = S_DONE;
                    end else if (count_inc == MAX_LEN_W) begin
                        trunc_nxt = 1'b1;
                        state_nxt = S_DONE;
                    end
                end
            end
`ifdef TEXT_WR_NULL_TERM_EN
            S_TERM: begin
                we_nxt    = 1'b1;
                waddr_nxt = wr_ptr;
                wdata_nxt = 8'h00;
                ptr_nxt   = wr_ptr + 1'b1;
                state_nxt = S_DESC;
            end
`endif
            S_DESC: begin
                if (desc_ack) state_nxt = trunc ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: begin
                // Remainder of a cut string is swallowed up to its final char.
                if (accept && char_last) begin
                    trunc_nxt = 1'b0;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            start     <= '0;
            count     <= '0;
            trunc     <= 1'b0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_nxt;
            wr_ptr    <= ptr_nxt;
            start     <= start_nxt;
            count     <= count_nxt;
            trunc     <= trunc_nxt;
            mem_we    <= we_nxt;
            mem_waddr <= waddr_nxt;
            mem_wdata <= wdata_nxt;
        end
    end

endmodule
